// File: rtl/out_core_port_pkg.sv
// ----------------------------------------------------------------------------
// out_core_port_pkg
//
// Shared constants for the output path of the PE array. The burst lengths
// are the same constants the output-bus arbiter is built with, so a port and
// the arbiter always agree on how many beats a granted burst lasts.
//
// Contents:
//   OUT_ARB_FIXED_BURST_WRITE : beats per write burst (port -> bus)
//   OUT_ARB_FIXED_BURST_READ  : beats per read burst  (bus -> port)
//   OUT_PORT_DATA_WIDTH       : data word width on core and bus sides
//   OUT_PORT_FIFO_DEPTH       : result FIFO entries per port
//   phase_t                   : which kind of burst the next grant serves
//   max_int()                 : helper used to size beat counters
// ----------------------------------------------------------------------------
package out_core_port_pkg;

    localparam int OUT_ARB_FIXED_BURST_WRITE = 4;
    localparam int OUT_ARB_FIXED_BURST_READ  = 4;

    localparam int OUT_PORT_DATA_WIDTH = 8;
    localparam int OUT_PORT_FIFO_DEPTH = 16;

    typedef enum logic {
        PHASE_WRITE = 1'b0,
        PHASE_READ  = 1'b1
    } phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : out_core_port_pkg

// File: rtl/out_core_port_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock FIFO with an occupancy count. Depth need not be a power of
// two: read and write pointers wrap with an explicit compare against the last
// index. A push while full or a pop while empty is ignored, so callers may
// drive push/pop from raw request signals.
//
// Ports:
//   w_clock      : clock, rising edge
//   w_reset      : synchronous active-high reset, empties the FIFO
//   w_push       : write w_push_data this cycle (ignored when full)
//   w_push_data  : word to store
//   w_pop        : remove the head word this cycle (ignored when empty)
//   w_pop_data   : current head word (valid when not empty)
//   w_full       : count == FIFO_DEPTH
//   w_empty      : count == 0
//   w_count      : current occupancy
// ----------------------------------------------------------------------------
module sync_fifo
    import out_core_port_pkg::*;
#(
    parameter int DATA_WIDTH = OUT_PORT_DATA_WIDTH,
    parameter int FIFO_DEPTH = OUT_PORT_FIFO_DEPTH,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  w_clock,
    input  logic                  w_reset,
    input  logic                  w_push,
    input  logic [DATA_WIDTH-1:0] w_push_data,
    input  logic                  w_pop,
    output logic [DATA_WIDTH-1:0] w_pop_data,
    output logic                  w_full,
    output logic                  w_empty,
    output logic [CNT_WIDTH-1:0]  w_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  push_ok;
    logic                  pop_ok;

    assign w_full     = (count == CNT_WIDTH'(FIFO_DEPTH));
    assign w_empty    = (count == '0);
    assign w_count    = count;
    assign w_pop_data = mem[rd_ptr];

    assign push_ok = w_push && !w_full;
    assign pop_ok  = w_pop  && !w_empty;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage array carries no reset; only pointers and count define contents.
    always_ff @(posedge w_clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= w_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/out_core_port.sv
// ----------------------------------------------------------------------------
// out_core_port
//
// Bus port for one PE core, sitting just upstream of the output-bus arbiter.
// Result words from the core are buffered in a FIFO. Once a full write burst
// is available the port requests the bus and streams BURST_WRITE words when
// granted; the next grant is always used for a BURST_READ-beat read burst
// whose words are forwarded to the core. Write and read bursts alternate.
//
// Ports:
//   w_clock        : clock, rising edge
//   w_reset        : synchronous active-high reset
//   w_pe_data      : result word from the core
//   w_pe_valid     : result word present
//   w_pe_ready     : FIFO can take a word (forced high during reset)
//   w_grant        : this core's grant bit from the arbiter
//   r_req          : registered request to the arbiter
//   w_bus_wdata    : write-beat data (FIFO head)
//   w_bus_wvalid   : write beat valid
//   w_bus_rdata    : read-beat data from the bus
//   w_bus_rvalid   : read beat valid
//   r_core_rdata   : operand word to the core
//   r_core_rvalid  : one-cycle pulse per operand word
//   w_fifo_count   : FIFO occupancy
//   r_err          : sticky, set when a burst lost its grant early
// ----------------------------------------------------------------------------
module out_core_port
    import out_core_port_pkg::*;
#(
    parameter int DATA_WIDTH  = OUT_PORT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = OUT_PORT_FIFO_DEPTH,
    parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH + 1),
    parameter int BURST_WRITE = OUT_ARB_FIXED_BURST_WRITE,
    parameter int BURST_READ  = OUT_ARB_FIXED_BURST_READ
) (
    input  logic                  w_clock,
    input  logic                  w_reset,
    input  logic [DATA_WIDTH-1:0] w_pe_data,
    input  logic                  w_pe_valid,
    output logic                  w_pe_ready,
    input  logic                  w_grant,
    output logic                  r_req,
    output logic [DATA_WIDTH-1:0] w_bus_wdata,
    output logic                  w_bus_wvalid,
    input  logic [DATA_WIDTH-1:0] w_bus_rdata,
    input  logic                  w_bus_rvalid,
    output logic [DATA_WIDTH-1:0] r_core_rdata,
    output logic                  r_core_rvalid,
    output logic [CNT_WIDTH-1:0]  w_fifo_count,
    output logic                  r_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WREQ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_RREQ  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam int BEAT_W = $clog2(max_int(BURST_WRITE, BURST_READ) + 1);

    logic [2:0]        state;
    phase_t            phase;
    logic [BEAT_W-1:0] beat_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;

    // Ready comes from the registered count only, so a full FIFO refuses a
    // word even if a pop happens in the same cycle.
    assign w_pe_ready = w_reset || !fifo_full;
    assign fifo_push  = w_pe_valid && !fifo_full;

    // A write beat is only driven while the grant is still held; in the cycle
    // the grant disappears nothing is popped, so unsent words stay queued.
    assign w_bus_wvalid = (state == S_WRITE) && w_grant && !fifo_empty && !w_reset;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .w_clock     (w_clock),
        .w_reset     (w_reset),
        .w_push      (fifo_push),
        .w_push_data (w_pe_data),
        .w_pop       (w_bus_wvalid),
        .w_pop_data  (w_bus_wdata),
        .w_full      (fifo_full),
        .w_empty     (fifo_empty),
        .w_count     (w_fifo_count)
    );

    // Burst sequencer. The phase flips on every accepted grant, so a grant
    // that is lost mid-burst still consumes its turn and the next grant is
    // used for the other burst type. GAP holds until the arbiter releases the
    // grant so the dropped request is always visible for at least one cycle.
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state         <= S_IDLE;
            phase         <= PHASE_WRITE;
            beat_cnt      <= '0;
            r_req         <= 1'b0;
            r_core_rdata  <= '0;
            r_core_rvalid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_core_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (phase == PHASE_READ) begin
                        state <= S_RREQ;
                        r_req <= 1'b1;
                    end else if (w_fifo_count >= CNT_WIDTH'(BURST_WRITE)) begin
                        state <= S_WREQ;
                        r_req <= 1'b1;
                    end
                end
                S_WREQ: begin
                    if (w_grant) begin
                        state    <= S_WRITE;
                        beat_cnt <= '0;
                        phase    <= PHASE_READ;
                    end
                end
                S_WRITE: begin
                    if (!w_grant) begin
                        r_err <= 1'b1;
                        r_req <= 1'b0;
                        state <= S_IDLE;
                    end else if (w_bus_wvalid) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == BEAT_W'(BURST_WRITE - 1)) begin
                            r_req <= 1'b0;
                            state <= S_GAP;
                        end
                    end
                end
                S_RREQ: begin
                    if (w_grant) begin
                        state    <= S_READ;
                        beat_cnt <= '0;
                        phase    <= PHASE_WRITE;
                    end
                end
                S_READ: begin
                    if (!w_grant) begin
                        r_err <= 1'b1;
                        r_req <= 1'b0;
                        state <= S_IDLE;
                    end else if (w_bus_rvalid) begin
                        r_core_rdata  <= w_bus_rdata;
                        r_core_rvalid <= 1'b1;
                        beat_cnt      <= beat_cnt + BEAT_W'(1);
                        if (beat_cnt == BEAT_W'(BURST_READ - 1)) begin
                            r_req <= 1'b0;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!w_grant) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    r_req <= 1'b0;
                end
            endcase
        end
    end

endmodule : out_core_port

// File: tb/tb_out_core_port.sv
// ----------------------------------------------------------------------------
// tb_out_core_port
//
// Directed bench for out_core_port: reset, write burst, read burst with a
// gap beat, full-FIFO behaviour, grant loss and post-burst grant hold.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_out_core_port;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pe_data;
    logic       pe_valid;
    logic       pe_ready;
    logic       grant;
    logic       req;
    logic [7:0] bus_wdata;
    logic       bus_wvalid;
    logic [7:0] bus_rdata;
    logic       bus_rvalid;
    logic [7:0] core_rdata;
    logic       core_rvalid;
    logic [4:0] fifo_count;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    out_core_port dut (
        .w_clock       (clk),
        .w_reset       (rst),
        .w_pe_data     (pe_data),
        .w_pe_valid    (pe_valid),
        .w_pe_ready    (pe_ready),
        .w_grant       (grant),
        .r_req         (req),
        .w_bus_wdata   (bus_wdata),
        .w_bus_wvalid  (bus_wvalid),
        .w_bus_rdata   (bus_rdata),
        .w_bus_rvalid  (bus_rvalid),
        .r_core_rdata  (core_rdata),
        .r_core_rvalid (core_rvalid),
        .w_fifo_count  (fifo_count),
        .r_err         (err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pe_valid   = 1'b0;
        pe_data    = 8'h00;
        grant      = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 8'h00;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        pe_valid = 1'b1;
        pe_data  = d;
        step();
        pe_valid = 1'b0;
    endtask

    task automatic wait_req(input int max_cycles, input string name);
        int n;
        n = 0;
        while (req !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s: req=%b after %0d cycles, required 1", name, req, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pe_valid = 1'b0; pe_data = 8'h00; grant = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = 8'h00;
        step(); step();
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d required 0", fifo_count); end
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b required 0", req); end
        checks++; if (bus_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wvalid: got %b required 0", bus_wvalid); end
        checks++; if (pe_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_pe_ready: got %b required 1", pe_ready); end
        checks++; if (core_rvalid !== 1'b0 || core_rdata !== 8'h00) begin failures++; $display("[TB] FAIL rst_core: got rvalid=%b rdata=%h required 0/00", core_rvalid, core_rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b required 0", err); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
        wait_req(4, "midrst_req");
        grant = 1'b1;
        step();
        step();
        step();
        checks++; if (fifo_count !== 5'd2) begin failures++; $display("[TB] FAIL midrst_two_beats: count got %0d required 2", fifo_count); end
        rst = 1'b1;
        step();
        checks++; if (fifo_count !== 5'd0) begin failures++; $display("[TB] FAIL midrst_count: got %0d required 0", fifo_count); end
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL midrst_req: got %b required 0", req); end
        checks++; if (bus_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wvalid: got %b required 0", bus_wvalid); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_err: got %b required 0", err); end
        rst   = 1'b0;
        grant = 1'b0;
        push_word(8'hD1); push_word(8'hD2); push_word(8'hD3);
        for (int i = 0; i < 6; i++) step();
        checks++; if (req !== 1'b0 || fifo_count !== 5'd3) begin failures++; $display("[TB] FAIL midrst_three_no_req: got req=%b count=%0d required 0/3", req, fifo_count); end
    endtask

    task automatic test_write_burst();
        logic [7:0] wexp [4];
        wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) push_word(wexp[i]);
        wait_req(4, "write_req");
        grant = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_wvalid !== 1'b1 || bus_wdata !== wexp[i] || req !== 1'b1) begin
                failures++;
                $display("[TB] FAIL write_beat%0d: got wvalid=%b wdata=%h req=%b required 1/%h/1", i, bus_wvalid, bus_wdata, req, wexp[i]);
            end
            step();
        end
        checks++; if (req !== 1'b0 || bus_wvalid !== 1'b0 || fifo_count !== 5'd0) begin failures++; $display("[TB] FAIL write_end: got req=%b wvalid=%b count=%0d required 0/0/0", req, bus_wvalid, fifo_count); end
        grant = 1'b0;
        step();
    endtask

    task automatic test_read_burst();
        logic       rv [5];
        logic [7:0] rd [5];
        rv[0] = 1'b1; rd[0] = 8'hA0;
        rv[1] = 1'b0; rd[1] = 8'h5A;
        rv[2] = 1'b1; rd[2] = 8'hA1;
        rv[3] = 1'b1; rd[3] = 8'hA2;
        rv[4] = 1'b1; rd[4] = 8'hA3;
        wait_req(4, "read_req");
        grant = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            bus_rvalid = rv[k];
            bus_rdata  = rd[k];
            step();
            checks++;
            if (core_rvalid !== rv[k]) begin
                failures++;
                $display("[TB] FAIL read_rvalid%0d: got %b required %b", k, core_rvalid, rv[k]);
            end
            if (rv[k]) begin
                checks++;
                if (core_rdata !== rd[k]) begin
                    failures++;
                    $display("[TB] FAIL read_data%0d: got %h required %h", k, core_rdata, rd[k]);
                end
            end
            checks++;
            if (req !== ((k == 4) ? 1'b0 : 1'b1)) begin
                failures++;
                $display("[TB] FAIL read_req%0d: got %b required %b", k, req, (k == 4) ? 1'b0 : 1'b1);
            end
        end
        bus_rvalid = 1'b0;
        step();
        checks++; if (core_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL read_pulse_end: got %b required 0", core_rvalid); end
        grant = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (req !== 1'b0 || bus_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL read_back_to_write_idle: got req=%b wvalid=%b required 0/0", req, bus_wvalid); end
    endtask

    task automatic test_fill();
        do_reset();
        pe_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pe_data = 8'h30 + 8'(i);
            step();
        end
        checks++; if (pe_ready !== 1'b0 || fifo_count !== 5'd16) begin failures++; $display("[TB] FAIL fill_full: got ready=%b count=%0d required 0/16", pe_ready, fifo_count); end
        checks++; if (req !== 1'b1) begin failures++; $display("[TB] FAIL fill_req: got %b required 1", req); end
        pe_data = 8'h55;
        step();
        checks++; if (fifo_count !== 5'd16) begin failures++; $display("[TB] FAIL fill_no_overflow: got %0d required 16", fifo_count); end
        grant = 1'b1;
        step();
        checks++; if (bus_wvalid !== 1'b1 || bus_wdata !== 8'h30 || pe_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_first_beat: got wvalid=%b wdata=%h ready=%b required 1/30/0", bus_wvalid, bus_wdata, pe_ready); end
        step();
        checks++; if (fifo_count !== 5'd15 || bus_wdata !== 8'h31 || pe_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_after_beat1: got count=%0d wdata=%h ready=%b required 15/31/1", fifo_count, bus_wdata, pe_ready); end
        for (int b = 2; b <= 4; b++) begin
            step();
            checks++;
            if (fifo_count !== 5'd15) begin
                failures++;
                $display("[TB] FAIL fill_pushpop_beat%0d: got count=%0d required 15", b, fifo_count);
            end
        end
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL fill_req_drop: got %b required 0", req); end
        pe_valid = 1'b0;
        grant    = 1'b0;
        step();
    endtask

    task automatic test_grant_loss();
        do_reset();
        push_word(8'h61); push_word(8'h62); push_word(8'h63); push_word(8'h64);
        wait_req(4, "loss_req");
        grant = 1'b1;
        step();
        checks++; if (bus_wdata !== 8'h61) begin failures++; $display("[TB] FAIL loss_head: got %h required 61", bus_wdata); end
        step();
        step();
        grant = 1'b0;
        #1;
        checks++; if (bus_wvalid !== 1'b0) begin failures++; $display("[TB] FAIL loss_wvalid_gated: got %b required 0", bus_wvalid); end
        step();
        checks++; if (err !== 1'b1 || fifo_count !== 5'd2 || req !== 1'b0) begin failures++; $display("[TB] FAIL loss_abort: got err=%b count=%0d req=%b required 1/2/0", err, fifo_count, req); end
        step();
        checks++; if (req !== 1'b1) begin failures++; $display("[TB] FAIL loss_read_req: got %b required 1", req); end
        grant = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 8'hB0 + 8'(k);
            step();
            checks++;
            if (core_rvalid !== 1'b1 || core_rdata !== 8'hB0 + 8'(k) || bus_wvalid !== 1'b0 || fifo_count !== 5'd2) begin
                failures++;
                $display("[TB] FAIL loss_read_beat%0d: got rvalid=%b rdata=%h wvalid=%b count=%0d required 1/%h/0/2", k, core_rvalid, core_rdata, bus_wvalid, fifo_count, 8'hB0 + 8'(k));
            end
        end
        bus_rvalid = 1'b0;
    endtask

    task automatic test_gap_hold();
        logic [7:0] wexp [4];
        wexp[0] = 8'h63; wexp[1] = 8'h64; wexp[2] = 8'h71; wexp[3] = 8'h72;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (req !== 1'b0 || err !== 1'b1) begin
                failures++;
                $display("[TB] FAIL gap_hold%0d: got req=%b err=%b required 0/1", i, req, err);
            end
        end
        grant = 1'b0;
        step(); step(); step();
        checks++; if (req !== 1'b0) begin failures++; $display("[TB] FAIL gap_short_fifo: got req=%b required 0", req); end
        push_word(8'h71);
        push_word(8'h72);
        wait_req(4, "gap_rereq");
        grant = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_wvalid !== 1'b1 || bus_wdata !== wexp[i]) begin
                failures++;
                $display("[TB] FAIL gap_write_beat%0d: got wvalid=%b wdata=%h required 1/%h", i, bus_wvalid, bus_wdata, wexp[i]);
            end
            step();
        end
        checks++; if (fifo_count !== 5'd0 || req !== 1'b0) begin failures++; $display("[TB] FAIL gap_write_end: got count=%0d req=%b required 0/0", fifo_count, req); end
        grant = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_reset_mid_write();
        test_write_burst();
        test_read_burst();
        test_fill();
        test_grant_loss();
        test_gap_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_out_core_port

// File: doc/out_core_port.md
Name: out_core_port

Overview:
- Per-PE-core bus port that sits directly upstream of the output-bus arbiter; one instance per core.
- Buffers result words produced by the PE core in a FIFO.
- Raises a request to the arbiter and streams a fixed-size write burst onto the shared data bus when granted.
- On the next grant, it accepts a fixed-size read burst of operands from the bus and forwards the words to the core.

Parameters:
- DATA_WIDTH, 8, width of one data word on the core and bus sides.
- FIFO_DEPTH, 16, result FIFO entries; must be >= BURST_WRITE.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of the FIFO occupancy count.
- BURST_WRITE, `OUT_ARB_FIXED_BURST_WRITE (4), beats per write burst.
- BURST_READ, `OUT_ARB_FIXED_BURST_READ (4), beats per read burst.

Ports:
- w_clock  in  1  clock; all state updates on the rising edge.
- w_reset  in  1  synchronous, active-high reset.
- w_pe_data  in  DATA_WIDTH  result word from the PE core.
- w_pe_valid  in  1  result word present.
- w_pe_ready  out  1  FIFO can accept a word (~full).
- w_grant  in  1  this core's grant bit from the arbiter.
- r_req  out  1  request to the arbiter.
- w_bus_wdata  out  DATA_WIDTH  write-beat data (FIFO head).
- w_bus_wvalid  out  1  write beat valid.
- w_bus_rdata  in  DATA_WIDTH  read-beat data from the bus.
- w_bus_rvalid  in  1  read beat valid.
- r_core_rdata  out  DATA_WIDTH  operand word to the core.
- r_core_rvalid  out  1  operand valid; one-cycle pulse per word; no backpressure.
- w_fifo_count  out  CNT_WIDTH  FIFO occupancy.
- r_err  out  1  sticky flag: a burst was aborted.

Behaviour:
- Reset (w_reset=1 at an edge, including mid-burst): state=IDLE, FIFO flushed (count=0), phase=WRITE, r_req=0, r_core_rdata=0, r_core_rvalid=0, r_err=0, beat counter=0. While in reset, w_bus_wvalid=0 and w_pe_ready=1.
- FIFO:
  - Push when w_pe_valid && w_pe_ready.
  - Pop when w_bus_wvalid at an edge.
  - Push and pop in the same cycle leave the count unchanged.
  - w_pe_ready = (count != FIFO_DEPTH), derived from the registered count; there is no write-through when full.
- States: IDLE, WREQ, WRITE, RREQ, READ, GAP.
- IDLE:
  - If phase=WRITE and count >= BURST_WRITE, go to WREQ.
  - If phase=READ, go to RREQ.
- WREQ: r_req=1. When w_grant=1 at an edge, go to WRITE, clear the beat counter, toggle phase.
- WRITE:
  - w_bus_wvalid=1 combinationally; w_bus_wdata = FIFO head.
  - Pop one word per cycle.
  - The first beat occurs in the cycle after the grant is sampled.
  - r_req stays 1 until the edge that completes beat BURST_WRITE. It drops to 0 in that same cycle, then go to GAP.
- RREQ: r_req=1. When w_grant=1 at an edge, go to READ, clear the beat counter, toggle phase.
- READ:
  - Each cycle with w_bus_rvalid=1, register r_core_rdata <= w_bus_rdata and r_core_rvalid <= 1 (latency 1 cycle); otherwise r_core_rvalid <= 0.
  - Cycles without rvalid do not count as beats.
  - After BURST_READ valid beats, r_req <= 0 and go to GAP.
- GAP: wait for w_grant=0, then go to IDLE. This guarantees at least one idle cycle between bursts so the arbiter sees the request drop.
- Phase alternation: write and read strictly alternate, and phase toggles on every accepted grant.
- Grant loss: if w_grant falls in WRITE or READ before the burst completes:
  - Set r_err=1 (sticky) and r_req <= 0, then go to IDLE.
  - In WRITE, unpopped words remain in the FIFO.
  - Phase is not restored.
- Grant outside WREQ/WRITE/RREQ/READ/GAP is ignored. w_bus_wvalid=0 in every state except WRITE.
- The FIFO always has >= BURST_WRITE words on entry to WRITE, so it cannot underflow during a complete burst.
- Pointers wrap modulo FIFO_DEPTH; FIFO_DEPTH need not be a power of two (explicit wrap compare).

Decomposition:
- Shared parameters header gains OUT_PORT_DATA_WIDTH and OUT_PORT_FIFO_DEPTH. It reuses the existing OUT_ARB_FIXED_BURST_WRITE/READ so burst sizes stay consistent with the arbiter.
- State encodings are localparams in the module (3 bits).
- One sub-module: sync_fifo (DATA_WIDTH, FIFO_DEPTH; push/pop/full/empty/count; synchronous active-high reset on w_reset). It is reusable by other output-path stages.

Test Plan:
- Reset mid-WRITE after 2 of 4 beats:
  - Next cycle: count=0, r_req=0, w_bus_wvalid=0, r_err=0.
  - After reset release: 3 pushes → no request.
- Push 0x11,0x22,0x33,0x44, then hold grant=1 one cycle after r_req rises:
  - w_bus_wdata=0x11,0x22,0x33,0x44 on 4 consecutive cycles with wvalid=1.
  - r_req drops on the 4th beat; count=0.
- Following the write, grant again; drive rvalid with 0xA0,gap,0xA1,0xA2,0xA3:
  - r_core_rvalid pulses 4 times, 1 cycle after each beat, with matching data.
  - Return to IDLE with phase=WRITE.
- Fill 16 words:
  - w_pe_ready=0 at count=16.
  - Push+pop in the same cycle during WRITE keeps count=15 after the first beat.
- Drop grant after 2 write beats:
  - r_err=1, count=2 (of 4), state IDLE.
  - Next grant is treated as a READ burst.
- Grant held high for 3 cycles after burst completion:
  - Port stays in GAP with r_req=0.
  - Re-requests only after grant=0 and count >= 4.
